// File: rtl/dsram_port_arbiter_pkg.sv
// Shared constants and the slot-arbitration rule for the data SRAM port arbiter.
package dsram_port_arbiter_pkg;

    localparam int SLOT0        = 0;
    localparam int SLOT1        = 1;
    localparam int DSRAM_WEN_WD = 4;

    // One-hot grant: a lone pending slot wins, otherwise the older slot per order.
    function automatic logic [1:0] arb_grant(input logic pend0, input logic pend1, input logic order);
        logic [1:0] g;
        g = {pend1, pend0};
        if (pend0 && pend1) begin
            g = order ? 2'b10 : 2'b01;
        end
        return g;
    endfunction

endpackage

// File: rtl/dsram_port_arbiter_req_mux.sv
// Pure 2:1 request mux onto the data SRAM port, steered by a one-hot grant.
// Zero latency; drives all-zero when nothing is granted.
module dsram_port_arbiter_req_mux
    import dsram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [1:0]              grant,
    input  logic [DSRAM_WEN_WD-1:0] s0_wen,
    input  logic [ADDR_W-1:0]       s0_addr,
    input  logic [DATA_W-1:0]       s0_wdata,
    input  logic [DSRAM_WEN_WD-1:0] s1_wen,
    input  logic [ADDR_W-1:0]       s1_addr,
    input  logic [DATA_W-1:0]       s1_wdata,
    output logic                    data_sram_en,
    output logic [DSRAM_WEN_WD-1:0] data_sram_wen,
    output logic [ADDR_W-1:0]       data_sram_addr,
    output logic [DATA_W-1:0]       data_sram_wdata
);

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (grant[SLOT0]) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = s0_wen;
            data_sram_addr  = s0_addr;
            data_sram_wdata = s0_wdata;
        end else if (grant[SLOT1]) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = s1_wen;
            data_sram_addr  = s1_addr;
            data_sram_wdata = s1_wdata;
        end
    end

endmodule

// File: rtl/dsram_port_arbiter.sv
// Shares the data SRAM port between both EX issue slots, serialising older-then-younger.
// Zero-cycle request latency; stallreq holds the bundle for the extra access cycle.
module dsram_port_arbiter
    import dsram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    ex_adv,
    input  logic                    order,
    input  logic                    s0_valid,
    input  logic                    s1_valid,
    input  logic                    s0_en,
    input  logic                    s1_en,
    input  logic [DSRAM_WEN_WD-1:0] s0_wen,
    input  logic [DSRAM_WEN_WD-1:0] s1_wen,
    input  logic [ADDR_W-1:0]       s0_addr,
    input  logic [ADDR_W-1:0]       s1_addr,
    input  logic [DATA_W-1:0]       s0_wdata,
    input  logic [DATA_W-1:0]       s1_wdata,
    output logic                    data_sram_en,
    output logic [DSRAM_WEN_WD-1:0] data_sram_wen,
    output logic [ADDR_W-1:0]       data_sram_addr,
    output logic [DATA_W-1:0]       data_sram_wdata,
    output logic [1:0]              grant,
    output logic                    stallreq,
    output logic                    rsp_valid,
    output logic                    rsp_slot,
    output logic [CNT_W-1:0]        conflict_cnt
);

    logic [1:0] done;
    logic       live;
    logic       pend0;
    logic       pend1;
    logic       conflict;

    // Reset and flush both suppress all port activity in the current cycle.
    assign live     = ~rst & ~flush;
    assign pend0    = live & s0_valid & s0_en & ~done[SLOT0];
    assign pend1    = live & s1_valid & s1_en & ~done[SLOT1];
    assign conflict = pend0 & pend1;
    assign stallreq = conflict;
    assign grant    = arb_grant(pend0, pend1, order);

    dsram_port_arbiter_req_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_mux (
        .grant           (grant),
        .s0_wen          (s0_wen),
        .s0_addr         (s0_addr),
        .s0_wdata        (s0_wdata),
        .s1_wen          (s1_wen),
        .s1_addr         (s1_addr),
        .s1_wdata        (s1_wdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    // A new bundle starts fresh even if its predecessor was granted this cycle.
    always_ff @(posedge clk) begin
        if (rst || flush || ex_adv) begin
            done <= 2'b00;
        end else begin
            done <= done | grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rsp_valid <= 1'b0;
            rsp_slot  <= 1'b0;
        end else begin
            rsp_valid <= |grant;
            rsp_slot  <= grant[SLOT1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && !(&conflict_cnt)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule
